// File: rtl/vec_dot_mac_pkg.sv
// Shared types and Q-format constants for the vec_dot_mac dot-product PE.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vec_dot_pkg;

    // Control FSM states of the dot-product engine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Default element format: Q1.4.11 in 16 bits
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_FRAC_W  = 11;
    localparam int DEF_VEC_LEN = 16;

    // 1.0 in the default Q format
    localparam logic [DEF_DATA_W-1:0] ONE = 16'h0800;

    // Half of one result LSB as seen in the full-precision accumulator
    // (products carry 2*FRAC_W fractional bits), used for round-half-up
    localparam int HALF_LSB = 1 << (DEF_FRAC_W - 1);

endpackage

// File: rtl/vec_dot_mac_if.sv
// Operand/result handshake bundle for vec_dot_mac (valid/ready both sides).
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry flow control; see vec_dot_mac.
interface vec_dot_mac_if
    import vec_dot_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int VEC_LEN = DEF_VEC_LEN
) ();

    logic                        in_valid;
    logic                        in_ready;
    logic [VEC_LEN*DATA_W-1:0]   vec_a;
    logic [VEC_LEN*DATA_W-1:0]   vec_b;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           dot_out;
    logic                        ovf;

    // Producer/consumer side (operand buffers + writeback stage)
    modport master (
        output in_valid, vec_a, vec_b, out_ready,
        input  in_ready, out_valid, dot_out, ovf
    );

    // Dot-product engine side
    modport slave (
        input  in_valid, vec_a, vec_b, out_ready,
        output in_ready, out_valid, dot_out, ovf
    );

endinterface

// File: rtl/vec_dot_mac_lane_sum.sv
// LANES signed multipliers feeding a pairwise adder tree, full precision.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the sum is consumed.
module vec_dot_lane_sum
    import vec_dot_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = 1,
    parameter int SUM_W  = 2*DATA_W + $clog2(LANES)
) (
    input  logic [LANES*DATA_W-1:0]  i_a,
    input  logic [LANES*DATA_W-1:0]  i_b,
    output logic signed [SUM_W-1:0]  o_sum
);

    // Heap-ordered tree: leaves at [LANES-1 .. 2*LANES-2], root at [0]
    localparam int NODES = 2*LANES - 1;

    logic signed [SUM_W-1:0]  w_node [NODES];
    logic signed [DATA_W-1:0] w_ak;
    logic signed [DATA_W-1:0] w_bk;

    // Multiply each lane pair, then reduce pairwise towards the root
    always_comb begin
        w_ak = '0;
        w_bk = '0;
        for (int n = 0; n < NODES; n++) begin
            w_node[n] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            w_ak = i_a[k*DATA_W +: DATA_W];
            w_bk = i_b[k*DATA_W +: DATA_W];
            w_node[LANES-1+k] = SUM_W'(w_ak) * SUM_W'(w_bk);
        end
        for (int n = LANES - 2; n >= 0; n--) begin
            w_node[n] = w_node[2*n+1] + w_node[2*n+2];
        end
        o_sum = w_node[0];
    end

endmodule

// File: rtl/vec_dot_mac.sv
// Signed fixed-point dot product, LANES terms/cycle, full-precision acc, single rescale.
// Latency: out_valid K+1 cycles after accept (K=VEC_LEN/LANES); no re-accept until result taken.
// Backpressure: in_ready only in IDLE; result held stable while out_ready=0. Macro VEC_DOT_MAC_SAT_EN selects saturate vs wrap.
module vec_dot_mac
    import vec_dot_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int VEC_LEN = DEF_VEC_LEN,
    parameter int LANES   = 1,
    parameter int ACC_W   = 2*DATA_W + $clog2(VEC_LEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_dot_mac_if.slave   bus
);

    localparam int VEC_W  = VEC_LEN * DATA_W;
    localparam int LANE_W = LANES * DATA_W;
    localparam int SUM_W  = 2*DATA_W + $clog2(LANES);
    localparam int IDX_W  = $clog2(VEC_LEN + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - LANES);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

    // Rounding offset and DATA_W result range, expressed at accumulator+1 width
    localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_in_rdy;
    logic                     w_out_vld;
    logic                     w_accept;

    logic [VEC_W-1:0]         r_a;
    logic [VEC_W-1:0]         r_b;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_W-1:0]        r_dot;
    logic                     r_ovf;

    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W:0]    w_acc_ext;
    logic signed [ACC_W:0]    w_r;
    logic                     w_ovf_hi;
    logic                     w_ovf_lo;
    logic [DATA_W-1:0]        w_dot;

    assign w_accept = bus.in_valid && (r_state == IDLE);

    // Operands are shifted down each RUN cycle, so the lanes always read the low slice
    vec_dot_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SUM_W  (SUM_W)
    ) u_lane_sum (
        .i_a   (r_a[LANE_W-1:0]),
        .i_b   (r_b[LANE_W-1:0]),
        .o_sum (w_sum)
    );

    // Round half toward +inf, then range-check against the DATA_W signed range
    assign w_acc_ext = {r_acc[ACC_W-1], r_acc};
    assign w_r       = (w_acc_ext + HALF) >>> FRAC_W;
    assign w_ovf_hi  = (w_r > MAXV);
    assign w_ovf_lo  = (w_r < MINV);

`ifdef VEC_DOT_MAC_SAT_EN
    assign w_dot = w_ovf_hi ? MAXV[DATA_W-1:0] :
                   w_ovf_lo ? MINV[DATA_W-1:0] : w_r[DATA_W-1:0];
`else
    assign w_dot = w_r[DATA_W-1:0];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_out_vld   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_rdy = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                w_out_vld = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and result registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_idx <= '0;
            r_dot <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.vec_a;
                        r_b   <= bus.vec_b;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                RUN: begin
                    r_acc <= r_acc + ACC_W'(w_sum);
                    r_idx <= r_idx + STEP;
                    r_a   <= r_a >> LANE_W;
                    r_b   <= r_b >> LANE_W;
                end
                FIN: begin
                    r_dot <= w_dot;
                    r_ovf <= w_ovf_hi || w_ovf_lo;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = w_out_vld;
    assign bus.dot_out   = r_dot;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_vec_dot_mac.sv
// Directed bench for vec_dot_mac: default build (LANES=1) plus a LANES=4 instance.
// Latency: checks out_valid timing against K+1 after accept.
// Backpressure: exercises out_ready hold and mid-operation reset.
module tb_vec_dot_mac;

    localparam int DW = 16;
    localparam int VL = 16;
    localparam int VW = DW * VL;

    logic core_clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    vec_dot_mac_if #(.DATA_W(DW), .VEC_LEN(VL)) if0 ();
    vec_dot_mac_if #(.DATA_W(DW), .VEC_LEN(VL)) if4 ();

    vec_dot_mac #(.LANES(1)) dut0 (
        .clk   (core_clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    vec_dot_mac #(.LANES(4)) dut4 (
        .clk   (core_clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] splat(input logic [DW-1:0] e);
        logic [VW-1:0] v;
        for (int i = 0; i < VL; i++) v[i*DW +: DW] = e;
        return v;
    endfunction

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    // Accept one pair on dut0, check latency and result, then retire it
    task automatic run0(input string tag, input logic [VW-1:0] va, input logic [VW-1:0] vb,
                        input logic [DW-1:0] exp_dot, input logic exp_ovf);
        int lat;
        check({tag, "_in_ready"}, if0.in_ready, 1);
        if0.vec_a     = va;
        if0.vec_b     = vb;
        if0.in_valid  = 1'b1;
        if0.out_ready = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        if0.vec_a    = {VW{1'b1}};
        if0.vec_b    = {VW{1'b1}};
        lat = 0;
        while (!if0.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, 17);
        check({tag, "_dot"}, if0.dot_out, exp_dot);
        check({tag, "_ovf"}, if0.ovf, exp_ovf);
        tick();
        check({tag, "_done"}, {if0.out_valid, if0.in_ready}, 2'b01);
    endtask

    logic [VW-1:0] va;
    logic [VW-1:0] vb;
    logic [DW-1:0] hold_dot;
    logic [DW-1:0] exp_big;
    int            lat;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.vec_a = '0; if0.vec_b = '0;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.vec_a = '0; if4.vec_b = '0;
        repeat (3) tick();

        check("rst_dut0", {if0.in_ready, if0.out_valid, if0.ovf, if0.dot_out}, {3'b100, 16'h0000});
        check("rst_dut4", {if4.in_ready, if4.out_valid, if4.ovf, if4.dot_out}, {3'b100, 16'h0000});
        rst_n = 1'b1;
        tick();

        // 16 x (1.0 * 0.5) = 8.0
        run0("half", splat(16'h0800), splat(16'h0400), 16'h4000, 1'b0);

        // 16 x (1.0 * 1.0) = 16.0, out of range
`ifdef VEC_DOT_MAC_SAT_EN
        exp_big = 16'h7FFF;
`else
        exp_big = 16'h8000;
`endif
        run0("ovf_pos", splat(16'h0800), splat(16'h0800), exp_big, 1'b1);

        // 16 x (1.0 * -1.0) = -16.0, exactly representable
        run0("neg16", splat(16'h0800), splat(16'hF800), 16'h8000, 1'b0);

        // Half-LSB ties round up
        va = '0; vb = '0; va[15:0] = 16'h0001; vb[15:0] = 16'h0400;
        run0("rnd_pos", va, vb, 16'h0001, 1'b0);
        va[15:0] = 16'hFFFF;
        run0("rnd_neg", va, vb, 16'h0000, 1'b0);

        // LANES=4: latency 5, then hold under backpressure
        check("l4_in_ready", if4.in_ready, 1);
        if4.vec_a    = splat(16'h0800);
        if4.vec_b    = splat(16'h0400);
        if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0;
        if4.vec_a    = '0;
        lat = 0;
        while (!if4.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("l4_lat", lat, 5);
        check("l4_dot", if4.dot_out, 16'h4000);
        hold_dot = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("l4_hold", {if4.out_valid, if4.in_ready, if4.dot_out}, {2'b10, hold_dot});
        end
        if4.out_ready = 1'b1;
        tick();
        check("l4_release", {if4.out_valid, if4.in_ready}, 2'b01);

        // Reset in RUN cycle 6 abandons the computation
        if0.vec_a    = splat(16'h0800);
        if0.vec_b    = splat(16'hF800);
        if0.in_valid = 1'b1;
        tick();
        if0.in_valid = 1'b0;
        repeat (5) tick();
        check("mid_busy", if0.in_ready, 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst", {if0.in_ready, if0.out_valid, if0.ovf, if0.dot_out}, {3'b100, 16'h0000});
        rst_n = 1'b1;
        tick();
        check("mid_quiet", if0.out_valid, 0);
        run0("post_rst", splat(16'h0800), splat(16'h0400), 16'h4000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
